// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle RV32M multiply/divide unit for the execute stage. An accepted
// request occupies the unit for a fixed 32 iterations and the result is
// presented together with a one-cycle done pulse.
//
// Ports:
//   clk        in   1      system clock, all state on posedge
//   reset      in   1      synchronous, active-high reset
//   start      in   1      request, sampled only in IDLE or DONE
//   funct3     in   3      RV32M op select (MUL..REMU)
//   operand_a  in   XLEN   rs1 value
//   operand_b  in   XLEN   rs2 value
//   rd_in      in   5      destination register index
//   busy       out  1      operation in flight, pipeline must hold
//   done       out  1      one-cycle pulse, result/rd_out valid
//   result     out  XLEN   operation result (held until next completion)
//   rd_out     out  5      destination index latched at accept
//
// Build option:
//   MULDIV_DIVIDER_EN  when defined, DIV/DIVU/REM/REMU are implemented.
//                      When undefined, those ops finish after a single busy
//                      cycle and return 0; multiplies are unaffected.
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] acc_q;     // product high half / partial remainder
  logic [XLEN-1:0] lo_q;      // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0] b_q;       // multiplicand / divisor magnitude
  logic            neg_q;     // negate final magnitude
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            finish;

  // ------------------------------------------------------------------------
  // Operand conditioning at accept
  // ------------------------------------------------------------------------
  logic            a_signed, b_signed;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            neg_flag;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign_a   = a_signed && operand_a[XLEN-1];
    sign_b   = b_signed && operand_b[XLEN-1];
    abs_a    = sign_a ? (~operand_a + 1'b1) : operand_a;
    abs_b    = sign_b ? (~operand_b + 1'b1) : operand_b;
    // Remainder takes the dividend's sign; everything else the XOR.
    neg_flag = (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
  end

  // ------------------------------------------------------------------------
  // One multiply iteration: conditional add into the high half, then shift
  // the 65-bit {carry, acc, lo} right by one.
  // ------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_acc_n, mul_lo_n;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_acc_n = mul_sum[XLEN:1];
    mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
  end

  logic [XLEN-1:0] step_acc, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] final_res;

`ifdef MULDIV_DIVIDER_EN
  // Special-case flags are captured at accept so the raw operands need not
  // be held beyond the dividend.
  logic [XLEN-1:0] a_raw_q;
  logic            div0_q;
  logic            ovf_q;

  // One restoring-divide iteration on a 33-bit working remainder.
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_sub;
  logic [XLEN-1:0] div_acc_n, div_lo_n;
  logic [XLEN-1:0] quo_s, rem_s, div_res;

  always_comb begin
    rem_sh    = {acc_q, lo_q[XLEN-1]};
    rem_ge    = (rem_sh >= {1'b0, b_q});
    // When rem_ge holds the difference is below 2^XLEN, so the truncated
    // subtraction is exact.
    rem_sub   = rem_sh[XLEN-1:0] - b_q;
    div_acc_n = rem_ge ? rem_sub : rem_sh[XLEN-1:0];
    div_lo_n  = {lo_q[XLEN-2:0], rem_ge};
  end

  always_comb begin
    step_acc = op_q[2] ? div_acc_n : mul_acc_n;
    step_lo  = op_q[2] ? div_lo_n  : mul_lo_n;
  end

  always_comb begin
    quo_s = neg_q ? (~step_lo + 1'b1) : step_lo;
    rem_s = neg_q ? (~step_acc + 1'b1) : step_acc;
    if (div0_q) begin
      div_res = op_q[1] ? a_raw_q : '1;
    end else if (ovf_q) begin
      div_res = op_q[1] ? '0 : a_raw_q;
    end else begin
      div_res = op_q[1] ? rem_s : quo_s;
    end
  end
`else
  always_comb begin
    step_acc = mul_acc_n;
    step_lo  = mul_lo_n;
  end
`endif

  always_comb begin
    prod    = {step_acc, step_lo};
    prod_s  = neg_q ? (~prod + 1'b1) : prod;
    mul_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIVIDER_EN
    final_res = op_q[2] ? div_res : mul_res;
`else
    final_res = op_q[2] ? '0 : mul_res;
`endif
  end

  // ------------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_CALC;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
`ifdef MULDIV_DIVIDER_EN
        if (cnt_q == CNT_LAST) begin
`else
        // Without a divider, divide ops retire after a single busy cycle.
        if ((cnt_q == CNT_LAST) || op_q[2]) begin
`endif
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_CALC;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
`ifdef MULDIV_DIVIDER_EN
      a_raw_q  <= '0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q  <= funct3;
        rd_q  <= rd_in;
        acc_q <= '0;
        lo_q  <= abs_a;
        b_q   <= abs_b;
        neg_q <= neg_flag;
`ifdef MULDIV_DIVIDER_EN
        a_raw_q <= operand_a;
        div0_q  <= (operand_b == '0);
        // Signed overflow only matters for DIV/REM (funct3 1x0).
        ovf_q   <= (funct3[2] && !funct3[0]) &&
                   (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
`endif
      end else if (state_q == ST_CALC) begin
        acc_q <= step_acc;
        lo_q  <= step_lo;
      end
      if (finish) begin
        result_q <= final_res;
      end
    end
  end

  assign busy   = (state_q == ST_CALC);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit: directed RV32M corner cases, timing of
// busy/done, back-to-back and ignored requests, mid-operation reset and a
// randomized run against a plain-arithmetic reference model. Adapts its
// expectations to whether MULDIV_DIVIDER_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_unit;

`ifdef MULDIV_DIVIDER_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int tests_run;
  int tests_failed;

  muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (!DIV_EN) return 32'h0;
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = sa / sb;   // 64-bit division cannot overflow; 2^31 truncates to 0x80000000
        return p[31:0];
      end
      3'd5: begin
        if (!DIV_EN) return 32'h0;
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (!DIV_EN) return 32'h0;
        if (b == 32'h0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (!DIV_EN) return 32'h0;
        if (b == 32'h0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op from a negedge, then follow it to done. Operands are
  // scrambled every cycle after accept; an optional extra start pulse is
  // injected at cycle pulse_at. Returns at the negedge of the done cycle.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int pulse_at);
    int k;
    int busy_bad;
    int exp_lat;
    exp_lat   = (f[2] && !DIV_EN) ? 2 : 33;
    funct3    = f;
    operand_a = a;
    operand_b = b;
    rd_in     = rd;
    start     = 1'b1;
    @(posedge clk);
    k        = 0;
    busy_bad = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (done) break;
      if (!busy) busy_bad++;
      start     = (k == pulse_at);
      funct3    = 3'($urandom);
      operand_a = $urandom;
      operand_b = $urandom;
      rd_in     = 5'($urandom);
    end
    start = 1'b0;
    $display("[TB] %s f3=%0d a=0x%08h b=0x%08h rd=%0d -> result=0x%08h rd_out=%0d lat=%0d",
             tag, f, a, b, rd, result, rd_out, k);
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_bad), 32'd0);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
  endtask

  task automatic count_done(input string tag, input int cycles, input int exp_cnt);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check(tag, 32'(n), 32'(exp_cnt));
  endtask

  logic [2:0]  d_f  [10];
  logic [31:0] d_a  [10];
  logic [31:0] d_b  [10];
  logic [31:0] d_ex [10];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    start        = 1'b0;
    funct3       = 3'd0;
    operand_a    = 32'h0;
    operand_b    = 32'h0;
    rd_in        = 5'd0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_rd", {27'b0, rd_out}, 32'd0);
    $display("[TB] reset released: busy=%0d done=%0d result=0x%08h", busy, done, result);

    // Directed cases with spec-given results.
    d_f[0] = 3'd0; d_a[0] = 32'h0000_0007; d_b[0] = 32'hFFFF_FFFD; d_ex[0] = 32'hFFFF_FFEB;
    d_f[1] = 3'd1; d_a[1] = 32'h8000_0000; d_b[1] = 32'h8000_0000; d_ex[1] = 32'h4000_0000;
    d_f[2] = 3'd3; d_a[2] = 32'hFFFF_FFFF; d_b[2] = 32'hFFFF_FFFF; d_ex[2] = 32'hFFFF_FFFE;
    d_f[3] = 3'd2; d_a[3] = 32'hFFFF_FFFF; d_b[3] = 32'hFFFF_FFFF; d_ex[3] = 32'hFFFF_FFFF;
    d_f[4] = 3'd4; d_a[4] = 32'hFFFF_FFF9; d_b[4] = 32'h0000_0002; d_ex[4] = 32'hFFFF_FFFD;
    d_f[5] = 3'd6; d_a[5] = 32'hFFFF_FFF9; d_b[5] = 32'h0000_0002; d_ex[5] = 32'hFFFF_FFFF;
    d_f[6] = 3'd5; d_a[6] = 32'h0000_0005; d_b[6] = 32'h0000_0000; d_ex[6] = 32'hFFFF_FFFF;
    d_f[7] = 3'd7; d_a[7] = 32'h0000_0005; d_b[7] = 32'h0000_0000; d_ex[7] = 32'h0000_0005;
    d_f[8] = 3'd4; d_a[8] = 32'h8000_0000; d_b[8] = 32'hFFFF_FFFF; d_ex[8] = 32'h8000_0000;
    d_f[9] = 3'd6; d_a[9] = 32'h8000_0000; d_b[9] = 32'hFFFF_FFFF; d_ex[9] = 32'h0000_0000;

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ex;
      ex = (d_f[i][2] && !DIV_EN) ? 32'h0 : d_ex[i];
      do_op($sformatf("dir%0d", i), d_f[i], d_a[i], d_b[i], 5'(i + 5), ex, 0);
      @(negedge clk);
    end

    // DIVU 10/3 (latency 2 and zero result when the divider is absent).
    do_op("divu_10_3", 3'd5, 32'd10, 32'd3, 5'd9, model(3'd5, 32'd10, 32'd3), 0);

    // Back-to-back: second op accepted in the DONE cycle of the first.
    @(negedge clk);
    do_op("b2b_first", 3'd0, 32'd1234, 32'd5678, 5'd3, model(3'd0, 32'd1234, 32'd5678), 0);
    do_op("b2b_second", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd4,
          model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678), 0);
    count_done("b2b_no_extra_done", 5, 0);

    // Start pulsed mid-CALC is ignored: one done only.
    do_op("ignored_pulse", 3'd1, 32'hFFFF_0001, 32'h0001_FFFF, 5'd17,
          model(3'd1, 32'hFFFF_0001, 32'h0001_FFFF), 10);
    count_done("ignored_no_extra_done", 40, 0);

    // Reset in the middle of CALC.
    funct3    = 3'd0;
    operand_a = 32'd99;
    operand_b = 32'd77;
    rd_in     = 5'd21;
    start     = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 15) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] mid-op reset: busy=%0d done=%0d result=0x%08h rd_out=%0d",
             busy, done, result, rd_out);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'h0);
    check("midrst_rd", {27'b0, rd_out}, 32'd0);
    count_done("midrst_no_done", 40, 0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f  = 3'($urandom);
      a  = rand_opnd();
      b  = rand_opnd();
      rd = 5'($urandom);
      do_op($sformatf("rnd%0d", i), f, a, b, rd, model(f, a, b), 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M multiply/divide unit in the execute stage. It consumes the two source operands read from the register file and produces a 32-bit result plus destination index for the writeback path into the register file. The pipeline stalls on `busy`. The writeback mux writes `result` to `rd_out` when `done` is high.

## Interface

Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `ITERS`, default 32: iteration count for the CALC state. Must equal `XLEN`.

Ports:
- `clk`  in  1  system clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when state is IDLE or DONE
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `operand_a`  in  32  rs1 value (register file `read_data_1`)
- `operand_b`  in  32  rs2 value (register file `read_data_2`)
- `rd_in`  in  5  destination register index
- `busy`  out  1  operation in flight; the pipeline must hold
- `done`  out  1  one-cycle pulse: `result` and `rd_out` are valid
- `result`  out  32  operation result
- `rd_out`  out  5  latched destination index

## Operation

States and transitions:
- IDLE: `start` → CALC.
- CALC: 5-bit counter runs from 0 to 31. At 31 → DONE.
- DONE: `start` → CALC (back-to-back accepted). Otherwise → IDLE.

Accept (`start` in IDLE or DONE):
- Latch `funct3` and `rd_in`.
- Latch absolute values of the operands, subject to signedness:
  - `operand_a` is signed for MULH, MULHSU, DIV, REM.
  - `operand_b` is signed for MULH, DIV, REM.
- Latch the result sign flag: sign(a) XOR sign(b) for MUL-type ops and DIV; sign(a) for REM.

Multiply:
- Radix-2 shift-add, one bit per cycle, into a 64-bit product.
- Negate the 64-bit product if the sign flag is set.
- MUL returns bits [31:0]. MULH, MULHSU and MULHU return bits [63:32].

Divide:
- Restoring, one quotient bit per cycle, with a 33-bit remainder.
- Negate the quotient or remainder according to the sign flag.

Special cases, applied at CALC→DONE and still taking the full latency:
- Divisor zero: DIV/DIVU return 0xFFFFFFFF. REM/REMU return `operand_a` as given.
- DIV of 0x80000000 by 0xFFFFFFFF returns 0x80000000. REM of the same operands returns 0.

`rd_out` equal to 0 is computed normally; the register file discards the write.

## Timing

- Reset values: state IDLE, counter 0, `busy`=0, `done`=0, `result`=0, `rd_out`=0.
- `start` accepted at edge N:
  - `busy`=1 for cycles N+1 through N+32.
  - `done`=1 in cycle N+33 only, with `result` and `rd_out` valid.
- `result` and `rd_out` hold until the next accept or reset.
- Latency is fixed at 33 cycles for every op and operand value.
- `start` while in CALC is ignored. No queueing.
- `start` in DONE: `done` stays 1 for that cycle, and the new op's `busy` rises at the next edge.
- Operands are sampled only at accept. Changes during CALC have no effect.
- `reset` in any state, including mid-CALC: next edge returns to IDLE with reset values. The partial result is discarded and `done` is never asserted for it.
- The register file writes on the negedge, so `result` is captured in the same cycle `done` is high.

## Configuration

Macro `MULDIV_DIVIDER_EN`:
- Defined: all eight ops as above.
- Undefined:
  - The divider datapath and special-case logic are not compiled.
  - Ops with `funct3[2]`=1 go IDLE→DONE with `done` at N+2. `busy` is high only in cycle N+1.
  - Those ops return `result`=0.
  - Multiply ops are unchanged.

## Test plan

- Reset held 3 cycles, then released → `busy`=0, `done`=0, `result`=0.
- MUL 7 × 0xFFFFFFFD, `rd_in`=5, `start` at N → `done` only at N+33, `result`=0xFFFFFFEB, `rd_out`=5.
- Upper-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide cases:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - Every divide case completes at N+33.
- Back-to-back and ignored requests:
  - `start` held in DONE → the second op completes at N+66.
  - `start` pulsed at N+10 → ignored, exactly one `done` seen.
- Mid-op reset and macro-off build:
  - `reset` at N+15 → idle next cycle, no `done` pulse.
  - With `MULDIV_DIVIDER_EN` undefined, DIVU 10 / 3 → `done` at N+2, `result`=0.
